// File: rtl/ppm_motor_pkg.sv
// rtl/ppm_motor_pkg.sv - state encoding, clamp helper and default codes shared by ppm_motor_out
package ppm_motor_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    FAILSAFE = 2'd2
  } ppm_state_e;

  localparam int DEF_MIN_CODE  = 16000;
  localparam int DEF_MAX_CODE  = 32000;
  localparam int DEF_IDLE_CODE = 22500;

  // Codes are widened to 32 bits so one helper serves every CODE_W.
  function automatic logic [31:0] clamp_code(input logic [31:0] v,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/ppm_channel.sv
// rtl/ppm_channel.sv - one motor channel: frame-latched active width and registered pulse comparator
// Per-frame slew limiting is compiled in with PPM_MOTOR_OUT_SLEW_EN.
module ppm_channel
  import ppm_motor_pkg::*;
#(
  parameter int CODE_W    = 16,
  parameter int CNT_W     = 16,
  parameter int MIN_CODE  = DEF_MIN_CODE,
  parameter int MAX_CODE  = DEF_MAX_CODE,
  parameter int SLEW_STEP = 256
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              load_i,
  input  logic              slew_en_i,
  input  logic [CODE_W-1:0] raw_i,
  input  logic [CODE_W-1:0] idle_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic              ppm_o
);

  localparam int CMP_W = (CNT_W > CODE_W) ? CNT_W : CODE_W;

  logic [CODE_W-1:0] active_q, active_d;
  logic [CODE_W-1:0] clamped;
  logic              ppm_q;

  assign clamped = CODE_W'(clamp_code(32'(raw_i), 32'(MIN_CODE), 32'(MAX_CODE)));

`ifdef PPM_MOTOR_OUT_SLEW_EN
  logic              slewed_q;
  logic [CODE_W-1:0] limited;
  logic [31:0]       base32, val32;

  // A fresh armed sequence ramps from idle, not from whatever test value was last driven.
  always_comb begin
    base32 = slewed_q ? 32'(active_q)
                      : clamp_code(32'(idle_i), 32'(MIN_CODE), 32'(MAX_CODE));
    val32  = 32'(clamped);
    if (val32 > base32 + 32'(SLEW_STEP)) begin
      val32 = base32 + 32'(SLEW_STEP);
    end else if (val32 + 32'(SLEW_STEP) < base32) begin
      val32 = base32 - 32'(SLEW_STEP);
    end
    limited = CODE_W'(val32);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      slewed_q <= 1'b0;
    end else if (load_i) begin
      slewed_q <= slew_en_i;
    end
  end

  always_comb begin
    active_d = active_q;
    if (load_i) begin
      active_d = slew_en_i ? limited : clamped;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{slew_en_i, idle_i, 32'(SLEW_STEP)};

  always_comb begin
    active_d = active_q;
    if (load_i) begin
      active_d = clamped;
    end
  end
`endif

  // Compare against the value being loaded so the first cycle of a frame uses the new width.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      ppm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      ppm_q    <= (CMP_W'(cnt_i) < CMP_W'(active_d));
    end
  end

  assign ppm_o = ppm_q;

endmodule

// File: rtl/ppm_motor_out.sv
// rtl/ppm_motor_out.sv - N-channel framed PPM motor output: shadow codes, arm/failsafe FSM, test override
// Optional slew limit in ppm_channel is enabled by defining PPM_MOTOR_OUT_SLEW_EN.
module ppm_motor_out
  import ppm_motor_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int CODE_W         = 16,
  parameter int PERIOD_CYC     = 65536,
  parameter int MIN_CODE       = DEF_MIN_CODE,
  parameter int MAX_CODE       = DEF_MAX_CODE,
  parameter int TIMEOUT_FRAMES = 8,
  parameter int SLEW_STEP      = 256
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [NCH*CODE_W-1:0] code,
  input  logic                  code_valid,
  input  logic [CODE_W-1:0]     idle_code,
  input  logic                  arm,
  input  logic                  test_en,
  input  logic [2:0]            test_sel,
  input  logic [CODE_W-1:0]     test_code,
  output logic [NCH-1:0]        ppm,
  output logic                  frame_start,
  output logic                  armed,
  output logic                  failsafe,
  output logic [NCH-1:0]        sat
);

  localparam int               CNT_W    = $clog2(PERIOD_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [7:0]       TMO_MAX  = 8'(TIMEOUT_FRAMES);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame0;
  logic [7:0]        tmo_q, tmo_d;
  ppm_state_e        state_q;
  logic              armed_q, failsafe_q, frame_start_q;
  logic [CODE_W-1:0] shadow_q [NCH];
  logic [NCH-1:0]    sat_q, sat_d;

  assign frame0 = (cnt_q == '0);
  assign cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    tmo_d = tmo_q;
    if (code_valid) begin
      tmo_d = '0;
    end else if (frame0 && (tmo_q < TMO_MAX)) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      tmo_q         <= '0;
      frame_start_q <= 1'b0;
      sat_q         <= '0;
      for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
    end else begin
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      frame_start_q <= frame0;
      if (code_valid) begin
        sat_q <= sat_d;
        for (int i = 0; i < NCH; i++) shadow_q[i] <= code[i*CODE_W +: CODE_W];
      end
    end
  end

  // Transitions use the timeout count including this frame boundary's increment.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= DISARMED;
      armed_q    <= 1'b0;
      failsafe_q <= 1'b0;
    end else if (frame0) begin
      case (state_q)
        DISARMED: begin
          if (arm && (tmo_d < TMO_MAX)) begin
            state_q <= ARMED;
            armed_q <= 1'b1;
          end
        end
        ARMED: begin
          if (!arm) begin
            state_q <= DISARMED;
            armed_q <= 1'b0;
          end else if (tmo_d == TMO_MAX) begin
            state_q    <= FAILSAFE;
            armed_q    <= 1'b0;
            failsafe_q <= 1'b1;
          end
        end
        FAILSAFE: begin
          if (!arm) begin
            state_q    <= DISARMED;
            failsafe_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= DISARMED;
          armed_q    <= 1'b0;
          failsafe_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CODE_W-1:0] code_ch, sel_code;
    logic              sel_slew;

    assign code_ch  = code[g*CODE_W +: CODE_W];
    assign sat_d[g] = (clamp_code(32'(code_ch), 32'(MIN_CODE), 32'(MAX_CODE)) != 32'(code_ch));

    always_comb begin
      sel_code = idle_code;
      sel_slew = 1'b0;
      if (test_en) begin
        if (int'(test_sel) == g) sel_code = test_code;
      end else if (state_q == ARMED) begin
        sel_code = shadow_q[g];
        sel_slew = 1'b1;
      end
    end

    ppm_channel #(
      .CODE_W    (CODE_W),
      .CNT_W     (CNT_W),
      .MIN_CODE  (MIN_CODE),
      .MAX_CODE  (MAX_CODE),
      .SLEW_STEP (SLEW_STEP)
    ) u_ch (
      .CLK       (CLK),
      .rst       (rst),
      .load_i    (frame0),
      .slew_en_i (sel_slew),
      .raw_i     (sel_code),
      .idle_i    (idle_code),
      .cnt_i     (cnt_q),
      .ppm_o     (ppm[g])
    );
  end

  assign frame_start = frame_start_q;
  assign armed       = armed_q;
  assign failsafe    = failsafe_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_ppm_motor_out.sv
// tb/tb_ppm_motor_out.sv - bench for ppm_motor_out: hand-derived phase table, random frames, async reset
module tb_ppm_motor_out;

  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int P    = 1000;
  localparam int MINC = 100;
  localparam int MAXC = 800;
  localparam int TMO  = 3;

  logic              CLK = 1'b0;
  logic              rst;
  logic [NCH*CW-1:0] code;
  logic              code_valid, arm, test_en;
  logic [CW-1:0]     idle_code, test_code;
  logic [2:0]        test_sel;
  logic [NCH-1:0]    ppm, sat;
  logic              frame_start, armed, failsafe;

  ppm_motor_out #(
    .NCH(NCH), .CODE_W(CW), .PERIOD_CYC(P), .MIN_CODE(MINC), .MAX_CODE(MAXC),
    .TIMEOUT_FRAMES(TMO), .SLEW_STEP(256)
  ) dut (
    .CLK(CLK), .rst(rst), .code(code), .code_valid(code_valid), .idle_code(idle_code),
    .arm(arm), .test_en(test_en), .test_sel(test_sel), .test_code(test_code),
    .ppm(ppm), .frame_start(frame_start), .armed(armed), .failsafe(failsafe), .sat(sat)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int                   nfr;
    logic                 arm;
    logic                 ten;
    int                   tsel;
    int                   tcode;
    int                   idle;
    int                   soff;
    logic [NCH-1:0][15:0] code;
    logic [NCH-1:0][15:0] ew;
    logic                 earm;
    logic                 efs;
    logic [NCH-1:0]       esat;
  } phase_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference: 0=disarmed 1=armed 2=failsafe
  int             c, m_state, m_tmo;
  int             m_shadow [NCH];
  logic [NCH-1:0] m_sat;
  int             m_w [NCH];
  int             hi [NCH];
  int             last_w [NCH];
  int             fs_cnt, frame_no;
  logic           fs_at0, last_armed, last_fs;
  logic [NCH-1:0] last_sat;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < MINC) ? MINC : ((v > MAXC) ? MAXC : v);
  endfunction

  function automatic phase_t mk(input int nfr, input logic a, input logic te, input int ts,
                                input int tc, input int idl, input int so,
                                input int c0, input int c1, input int c2, input int c3,
                                input int w0, input int w1, input int w2, input int w3,
                                input logic ea, input logic ef, input logic [3:0] es);
    phase_t p;
    p.nfr = nfr; p.arm = a; p.ten = te; p.tsel = ts; p.tcode = tc; p.idle = idl; p.soff = so;
    p.code[0] = 16'(c0); p.code[1] = 16'(c1); p.code[2] = 16'(c2); p.code[3] = 16'(c3);
    p.ew[0] = 16'(w0); p.ew[1] = 16'(w1); p.ew[2] = 16'(w2); p.ew[3] = 16'(w3);
    p.earm = ea; p.efs = ef; p.esat = es;
    return p;
  endfunction

  task automatic model_reset();
    c = 0; m_state = 0; m_tmo = 0; m_sat = '0; frame_no = 0;
    for (int i = 0; i < NCH; i++) m_shadow[i] = 0;
  endtask

  task automatic tick();
    int off;
    @(posedge CLK);
    off = c % P;
    if (off == 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (test_en) m_w[i] = (int'(test_sel) == i) ? clampi(int'(test_code)) : clampi(int'(idle_code));
        else if (m_state == 1) m_w[i] = clampi(m_shadow[i]);
        else m_w[i] = clampi(int'(idle_code));
      end
    end
    if (code_valid) m_tmo = 0;
    else if (off == 0 && m_tmo < TMO) m_tmo++;
    if (off == 0) begin
      if (m_state == 0 && arm && m_tmo < TMO) m_state = 1;
      else if (m_state == 1 && !arm) m_state = 0;
      else if (m_state == 1 && m_tmo == TMO) m_state = 2;
      else if (m_state == 2 && !arm) m_state = 0;
    end
    if (code_valid) begin
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = int'(code[i*CW +: CW]);
        m_sat[i]    = (m_shadow[i] < MINC) || (m_shadow[i] > MAXC);
      end
    end
    @(negedge CLK);
    if (off == 0) begin
      for (int i = 0; i < NCH; i++) hi[i] = 0;
      fs_cnt = 0; fs_at0 = frame_start; last_armed = armed; last_fs = failsafe;
      chk($sformatf("frame%0d armed", frame_no), int'(armed), int'(m_state == 1));
      chk($sformatf("frame%0d failsafe", frame_no), int'(failsafe), int'(m_state == 2));
    end
    fs_cnt += int'(frame_start);
    for (int i = 0; i < NCH; i++) hi[i] += int'(ppm[i]);
    if (off == P - 1) begin
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("frame%0d width ch%0d", frame_no, i), hi[i], m_w[i]);
        last_w[i] = hi[i];
      end
      chk($sformatf("frame%0d single frame_start at offset 0", frame_no),
          int'(fs_cnt == 1 && fs_at0), 1);
      chk($sformatf("frame%0d sat", frame_no), int'(sat), int'(m_sat));
      last_sat = sat;
      frame_no++;
    end
    c++;
  endtask

  task automatic run_frame(input int soff);
    for (int k = 0; k < P; k++) begin
      code_valid = (k == soff);
      tick();
    end
    code_valid = 1'b0;
  endtask

  phase_t tbl [13];

  initial begin
    tbl[0]  = mk(2, 0, 0, 0, 0,   300, -1,   0,   0,   0,   0, 300, 300, 300, 300, 0, 0, 4'b0000);
    tbl[1]  = mk(4, 1, 0, 0, 0,   300, 500, 500,  50, 900, 400, 500, 100, 800, 400, 1, 0, 4'b0110);
    tbl[2]  = mk(4, 1, 0, 0, 0,   300, -1,  500,  50, 900, 400, 300, 300, 300, 300, 0, 1, 4'b0110);
    tbl[3]  = mk(2, 1, 0, 0, 0,   300, 500, 500,  50, 900, 400, 300, 300, 300, 300, 0, 1, 4'b0110);
    tbl[4]  = mk(1, 0, 0, 0, 0,   300, 500, 500,  50, 900, 400, 300, 300, 300, 300, 0, 0, 4'b0110);
    tbl[5]  = mk(2, 1, 0, 0, 0,   300, 500, 500,  50, 900, 400, 500, 100, 800, 400, 1, 0, 4'b0110);
    tbl[6]  = mk(2, 0, 1, 2, 600, 300, -1,  500,  50, 900, 400, 300, 300, 600, 300, 0, 0, 4'b0110);
    tbl[7]  = mk(1, 0, 1, 5, 600, 300, -1,  500,  50, 900, 400, 300, 300, 300, 300, 0, 0, 4'b0110);
    tbl[8]  = mk(1, 0, 1, 0, 50,  900, -1,  500,  50, 900, 400, 100, 800, 800, 800, 0, 0, 4'b0110);
    tbl[9]  = mk(2, 1, 0, 0, 0,   300, 500, 100, 800, 200, 200, 300, 300, 300, 300, 1, 0, 4'b0000);
    tbl[10] = mk(1, 1, 0, 0, 0,   300, 500, 100, 800, 200, 200, 100, 800, 200, 200, 1, 0, 4'b0000);
    tbl[11] = mk(1, 1, 0, 0, 0,   300, 0,   700, 700, 700, 700, 100, 800, 200, 200, 1, 0, 4'b0000);
    tbl[12] = mk(1, 1, 0, 0, 0,   300, -1,  700, 700, 700, 700, 700, 700, 700, 700, 1, 0, 4'b0000);

    rst = 1'b1; code = '0; code_valid = 1'b0; idle_code = 16'd300; arm = 1'b0;
    test_en = 1'b0; test_sel = 3'd0; test_code = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("outputs held in reset", int'({ppm, frame_start, armed, failsafe, sat}), 0);
    rst = 1'b0;

    for (int r = 0; r < 13; r++) begin
      arm = tbl[r].arm; test_en = tbl[r].ten; test_sel = 3'(tbl[r].tsel);
      test_code = 16'(tbl[r].tcode); idle_code = 16'(tbl[r].idle);
      for (int i = 0; i < NCH; i++) code[i*CW +: CW] = tbl[r].code[i];
      for (int f = 0; f < tbl[r].nfr; f++) run_frame(tbl[r].soff);
      for (int i = 0; i < NCH; i++)
        chk($sformatf("row%0d table width ch%0d", r, i), last_w[i], int'(tbl[r].ew[i]));
      chk($sformatf("row%0d table armed", r), int'(last_armed), int'(tbl[r].earm));
      chk($sformatf("row%0d table failsafe", r), int'(last_fs), int'(tbl[r].efs));
      chk($sformatf("row%0d table sat", r), int'(last_sat), int'(tbl[r].esat));
    end

    for (int f = 0; f < 15; f++) begin
      arm       = ($urandom_range(0, 9) != 0);
      test_en   = ($urandom_range(0, 4) == 0);
      test_sel  = 3'($urandom_range(0, 7));
      test_code = 16'($urandom_range(0, 1000));
      idle_code = 16'($urandom_range(0, 1000));
      for (int i = 0; i < NCH; i++) code[i*CW +: CW] = 16'($urandom_range(0, 1000));
      run_frame(($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, P - 1)));
    end

    arm = 1'b0; test_en = 1'b0; idle_code = 16'd300;
    run_frame(-1);
    for (int k = 0; k <= 250; k++) begin
      code_valid = 1'b0;
      tick();
    end
    chk("ppm high at offset 250 before reset", int'(ppm), 15);
    #2 rst = 1'b1;
    #1 chk("outputs zero right after async reset", int'({ppm, frame_start, armed, failsafe, sat}), 0);
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    model_reset();
    run_frame(-1);
    run_frame(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ppm_motor_out.md
Name: ppm_motor_out

Overview:
- Parametrised N-channel PPM/servo-pulse motor output stage, the successor to the fixed 4-motor CODE2PPM fan-out in the flight controller top.
- Adds these behaviours:
  - frame-synchronous double-buffered update;
  - clamping;
  - arm/disarm state machine;
  - command-timeout failsafe;
  - per-channel host test override.
- Sits between the mixer/ADD_MULTIPLY outputs and the MOTOR pins, in the CLK domain.

Parameters:
- NCH, 4, number of motor channels (1..8)
- CODE_W, 16, width of pulse-width code in CLK cycles (unsigned)
- PERIOD_CYC, 65536, frame length in CLK cycles (must exceed MAX_CODE)
- MIN_CODE, 16000, lowest allowed pulse width
- MAX_CODE, 32000, highest allowed pulse width
- TIMEOUT_FRAMES, 8, frames without code_valid before failsafe (1..255)
- SLEW_STEP, 256, maximum per-frame change of a channel (used only with the optional feature)

Ports:
- CLK  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- code  in  NCH*CODE_W  packed channel codes; channel i is bits [i*CODE_W +: CODE_W]
- code_valid  in  1  one-cycle strobe; captures code into the shadow register
- idle_code  in  CODE_W  pulse width used when disarmed, in failsafe, or for non-selected test channels
- arm  in  1  host arm request (level)
- test_en  in  1  host test override enable
- test_sel  in  3  channel selected for test_code
- test_code  in  CODE_W  test pulse width for the selected channel
- ppm  out  NCH  pulse outputs
- frame_start  out  1  one-cycle pulse on the first cycle of each frame
- armed  out  1  high in state ARMED
- failsafe  out  1  high in state FAILSAFE
- sat  out  NCH  sticky per-channel clamp flag; cleared on rst or code_valid

Behaviour:
- Reset: all outputs 0, state DISARMED, frame counter 0, shadow and active registers 0, timeout counter 0.
- Frame counter:
  - runs 0..PERIOD_CYC-1 and wraps;
  - frame_start=1 when counter==0 (including the first cycle after reset release).
- Shadow register:
  - loaded on code_valid in any cycle;
  - sat[i] is set when channel i was clamped at load.
- Per-channel value selection at counter==0 (active register load):
  - test_en=1: channel test_sel gets test_code; other channels get idle_code. Test mode ignores state and timeout.
  - else state ARMED: shadow value.
  - else (DISARMED/FAILSAFE): idle_code.
  - All values, including test and idle, are clamped to [MIN_CODE, MAX_CODE] before entering the active register.
  - test_sel >= NCH selects no channel.
- Pulse generation:
  - ppm[i] is registered: ppm[i]=1 while counter < active[i], else 0.
  - Output latency is 1 cycle after the counter value, identical for all channels.
  - Active values never change mid-frame.
- code_valid coincident with counter==0: the active register loads the pre-strobe shadow; the new value applies from the next frame.
- Timeout counter:
  - cleared by code_valid;
  - incremented at each frame_start without code_valid, saturating at TIMEOUT_FRAMES.
- State machine (evaluated at counter==0 only):
  - DISARMED -> ARMED when arm=1 and timeout counter < TIMEOUT_FRAMES.
  - ARMED -> DISARMED when arm=0.
  - ARMED -> FAILSAFE when timeout counter == TIMEOUT_FRAMES.
  - FAILSAFE -> DISARMED when arm=0. Failsafe never re-arms without arm being deasserted first.
  - When arm=0 and timeout occur in the same frame, DISARMED wins.
- Reset mid-frame: ppm drops to 0 immediately (async). A new frame starts on the first cycle after release.

Optional Feature:
- Macro PPM_MOTOR_OUT_SLEW_EN.
- Defined:
  - in ARMED, each active load is limited to active_prev ± SLEW_STEP, applied after clamping;
  - entry to ARMED starts from idle_code;
  - test, disarm and failsafe loads bypass the limit.
- Undefined: active loads take the clamped value directly; SLEW_STEP is unused.

Decomposition:
- Shared package ppm_motor_pkg holds:
  - state enum (DISARMED=0, ARMED=1, FAILSAFE=2);
  - clamp function;
  - default MIN/MAX/idle constants (idle 22500).
- One sub-module, ppm_channel: holds the active register, optional slew logic and the comparator flop. It is instantiated NCH times via generate.
- The top holds the frame counter, shadow register, timeout and FSM.

Test Plan:
- Bench parameters PERIOD_CYC=1000, MIN=100, MAX=800, TIMEOUT=3.
- Reset release with arm=0, idle_code=300 -> every ppm high for exactly 300 cycles per frame; frame_start every 1000 cycles; armed=0.
- arm=1, code_valid each frame with ch0=500, ch1=50, ch2=900, ch3=400 -> from the next frame, widths 500/100/800/400; sat=0110; armed=1.
- Strobes stopped while armed -> widths unchanged for 3 frames; failsafe=1 at the 3rd missed frame_start; widths become 300 the following frame. Restarting strobes keeps failsafe until arm toggles 0 then 1.
- test_en=1, test_sel=2, test_code=600 while DISARMED -> ch2 width 600, others 300. test_sel=5 -> all channels 300.
- code_valid on a counter==0 cycle -> new code appears one frame later, never mid-frame.
- Async rst at counter=250 with ppm high -> ppm=0 within the same cycle; all outputs 0; a clean frame restarts after release.
